// File: rtl/dmem_sram_bridge.sv
// Data-side bridge: registers the core's M-stage access onto an SRAM-like req/addr_ok/data_ok bus.
// Define DMEM_TIMEOUT_EN to enable the access timeout, bus error pulse and stale-response discard.
module dmem_sram_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_sel,
    input  logic        cpu_flush,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_bus_err,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic timeout;      // counter expired this cycle
    logic stale;        // an abandoned response is still owed by the bus
    logic abandon;      // access given up this cycle
    logic abandon_acc;  // ... after the bus already accepted its address

    function automatic logic [1:0] sel_to_size(input logic [3:0] sel);
        logic [1:0] size;
        case (sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 2'd0;
            4'b0011, 4'b1100:                   size = 2'd1;
            default:                            size = 2'd2;
        endcase
        return size;
    endfunction

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        cpu_stall   = 1'b0;
        bus_req     = 1'b0;
        abandon     = 1'b0;
        abandon_acc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cpu_en && !cpu_flush) begin
                    cpu_stall = 1'b1;
                    if (!stale) begin
                        wr_d    = cpu_wr;
                        size_d  = sel_to_size(cpu_sel);
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                cpu_stall = 1'b1;
                bus_req   = 1'b1;
                if (bus_addr_ok && bus_data_ok) begin
                    if (!wr_q) rdata_d = bus_rdata;
                    state_d = StDone;
                end else if (timeout) begin
                    rdata_d     = 32'h0;
                    abandon     = 1'b1;
                    abandon_acc = bus_addr_ok;
                    state_d     = StDone;
                end else if (bus_addr_ok) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                cpu_stall = 1'b1;
                if (bus_data_ok) begin
                    if (!wr_q) rdata_d = bus_rdata;
                    state_d = StDone;
                end else if (timeout) begin
                    rdata_d     = 32'h0;
                    abandon     = 1'b1;
                    abandon_acc = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stale_q, stale_d;
    logic             err_q, err_d;

    always_comb begin
        cnt_d   = '0;
        stale_d = stale_q;
        err_d   = abandon;
        if (state_q == StReq || state_q == StWait) cnt_d = cnt_q + 1'b1;
        if (abandon_acc) begin
            stale_d = 1'b1;
        end else if (stale_q && bus_data_ok) begin
            stale_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            stale_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            stale_q <= stale_d;
            err_q   <= err_d;
        end
    end

    assign timeout     = (state_q == StReq || state_q == StWait) &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign stale       = stale_q;
    assign cpu_bus_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^{abandon, abandon_acc, CNT_W'(TIMEOUT_CYCLES)};
    assign timeout        = 1'b0;
    assign stale          = 1'b0;
    assign cpu_bus_err    = 1'b0;
`endif

    assign cpu_rdata = rdata_q;
    assign bus_wr    = wr_q;
    assign bus_size  = size_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Directed bench for dmem_sram_bridge; the timeout scenario follows DMEM_TIMEOUT_EN.
module tb_dmem_sram_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_en = 1'b0, cpu_wr = 1'b0, cpu_flush = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [3:0]  cpu_sel = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall, cpu_bus_err;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok = 1'b0, bus_data_ok = 1'b0;
    logic [31:0] bus_rdata = '0;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    dmem_sram_bridge dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_en     (cpu_en),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_sel    (cpu_sel),
        .cpu_flush  (cpu_flush),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .cpu_bus_err(cpu_bus_err),
        .bus_req    (bus_req),
        .bus_wr     (bus_wr),
        .bus_size   (bus_size),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok),
        .bus_rdata  (bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled at the falling edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic load(input logic [31:0] addr, input logic [3:0] sel);
        cpu_en = 1'b1; cpu_wr = 1'b0; cpu_addr = addr; cpu_sel = sel; cpu_wdata = '0;
    endtask

    logic [3:0]  sel_tab  [6] = '{4'b0011, 4'b1100, 4'b0001, 4'b1000, 4'b0110, 4'b0000};
    logic [1:0]  size_tab [6] = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2};

    initial begin
        // Reset state
        #3;
        check("rst_req", 32'(bus_req), 32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_addr", bus_addr, 32'h0);
        check("rst_err", 32'(cpu_bus_err), 32'd0);
        nxt(); nxt();
        rst = 1'b0;
        nxt();

        // LW word, zero-wait bus, then back-to-back load completing in REQ
        load(32'h8000_0010, 4'b1111);
        settle();
        check("lw_idle_stall", 32'(cpu_stall), 32'd1);
        check("lw_idle_req", 32'(bus_req), 32'd0);
        nxt();
        bus_addr_ok = 1'b1;
        settle();
        check("lw_req", {29'd0, bus_req, bus_wr, cpu_stall}, {29'd0, 3'b101});
        check("lw_size", 32'(bus_size), 32'd2);
        check("lw_addr", bus_addr, 32'h8000_0010);
        nxt();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        settle();
        check("lw_wait", {30'd0, bus_req, cpu_stall}, {30'd0, 2'b01});
        nxt();
        bus_data_ok = 1'b0; bus_rdata = '0;
        settle();
        check("lw_done_stall", 32'(cpu_stall), 32'd0);
        check("lw_rdata", cpu_rdata, 32'hDEAD_BEEF);
        nxt();
        load(32'h8000_0014, 4'b1111);
        settle();
        check("lw2_idle", {30'd0, bus_req, cpu_stall}, {30'd0, 2'b01});
        nxt();
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678;
        settle();
        check("lw2_req", 32'(bus_req), 32'd1);
        check("lw2_addr", bus_addr, 32'h8000_0014);
        nxt();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
        settle();
        check("lw2_done_stall", 32'(cpu_stall), 32'd0);
        check("lw2_rdata", cpu_rdata, 32'h1234_5678);
        nxt();
        cpu_en = 1'b0;

        // SB with addr_ok held low for 5 cycles
        cpu_en = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h8000_0002; cpu_sel = 4'b0100;
        cpu_wdata = 32'h00AB_0000;
        nxt();
        cpu_wdata = 32'h5555_5555;  // core data changing must not reach the bus
        for (int i = 0; i < 5; i++) begin
            settle();
            check("sb_hold_ctl", {28'd0, bus_req, bus_wr, bus_size}, {28'd0, 4'b1100});
            check("sb_hold_addr", bus_addr, 32'h8000_0002);
            check("sb_hold_wdata", bus_wdata, 32'h00AB_0000);
            nxt();
        end
        bus_addr_ok = 1'b1;
        nxt();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        nxt();
        bus_data_ok = 1'b0;
        settle();
        check("sb_done_stall", 32'(cpu_stall), 32'd0);
        check("sb_rdata_kept", cpu_rdata, 32'h1234_5678);
        nxt();
        cpu_en = 1'b0; cpu_wr = 1'b0;

        // Flush in IDLE suppresses; flush in REQ is ignored
        load(32'h8000_0040, 4'b1111);
        cpu_flush = 1'b1;
        settle();
        check("fl_idle", {30'd0, bus_req, cpu_stall}, 32'd0);
        nxt();
        settle();
        check("fl_idle2", {30'd0, bus_req, cpu_stall}, 32'd0);
        nxt();
        cpu_flush = 1'b0;
        nxt();
        cpu_flush = 1'b1; bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D;
        settle();
        check("fl_req", 32'(bus_req), 32'd1);
        nxt();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; cpu_flush = 1'b0;
        settle();
        check("fl_done_rdata", cpu_rdata, 32'hCAFE_F00D);
        nxt();
        cpu_en = 1'b0;

        // Size decode for the remaining sel patterns
        for (int i = 0; i < 6; i++) begin
            load(32'h8000_0100 + 32'(i), sel_tab[i]);
            nxt();
            bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hA000_0000 + 32'(i);
            settle();
            check("sz_size", 32'(bus_size), 32'(size_tab[i]));
            nxt();
            bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
            settle();
            check("sz_rdata", cpu_rdata, 32'hA000_0000 + 32'(i));
            nxt();
            cpu_en = 1'b0;
        end

        // Reset asserted mid-WAIT
        load(32'h8000_0200, 4'b1111);
        nxt();
        bus_addr_ok = 1'b1;
        nxt();
        bus_addr_ok = 1'b0;
        settle();
        check("rw_in_wait", {30'd0, bus_req, cpu_stall}, {30'd0, 2'b01});
        rst = 1'b1; cpu_en = 1'b0;
        #1;
        check("rw_ctl", {27'd0, bus_req, bus_wr, bus_size, cpu_stall}, 32'd0);
        check("rw_addr", bus_addr, 32'h0);
        check("rw_rdata", cpu_rdata, 32'h0);
        nxt();
        rst = 1'b0;
        nxt();
        load(32'h8000_0300, 4'b1111);
        nxt();
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h7777_0001;
        settle();
        check("rw_next_req", bus_addr, 32'h8000_0300);
        nxt();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        settle();
        check("rw_next_rdata", cpu_rdata, 32'h7777_0001);
        nxt();
        cpu_en = 1'b0;

        // Response never arrives after address accepted
        load(32'h8000_0400, 4'b1111);
        nxt();
        bus_addr_ok = 1'b1;
        nxt();
        bus_addr_ok = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        begin
            int k = 1;
            bit seen = 1'b0;
            settle();
            while (k <= 300 && !seen) begin
                if (cpu_bus_err) seen = 1'b1;
                else begin
                    nxt(); settle(); k++;
                end
            end
            check("to_err_seen", 32'(seen), 32'd1);
            check("to_err_cycle", 32'(k), 32'd255);
            check("to_done_stall", 32'(cpu_stall), 32'd0);
            check("to_rdata", cpu_rdata, 32'h0);
        end
        nxt();
        load(32'h8000_0500, 4'b1111);
        settle();
        check("to_err_pulse", 32'(cpu_bus_err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            nxt(); settle();
        end
        check("stale_block", {30'd0, bus_req, cpu_stall}, {30'd0, 2'b01});
        nxt();
        bus_data_ok = 1'b1; bus_rdata = 32'hBAD0_BAD0;
        settle();
        check("stale_discard", {30'd0, bus_req, cpu_stall}, {30'd0, 2'b01});
        nxt();
        bus_data_ok = 1'b0; bus_rdata = '0;
        settle();
        check("stale_rdata", cpu_rdata, 32'h0);
        nxt();
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h600D_F00D;
        settle();
        check("post_req", {31'd0, bus_req}, 32'd1);
        check("post_addr", bus_addr, 32'h8000_0500);
        nxt();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        settle();
        check("post_rdata", cpu_rdata, 32'h600D_F00D);
        check("post_err", 32'(cpu_bus_err), 32'd0);
`else
        begin
            bit held = 1'b1;
            for (int i = 0; i < 300; i++) begin
                settle();
                if (!cpu_stall || cpu_bus_err || bus_req) held = 1'b0;
                nxt();
            end
            check("nto_stall_held", 32'(held), 32'd1);
        end
        bus_data_ok = 1'b1; bus_rdata = 32'h0BAD_CAFE;
        nxt();
        bus_data_ok = 1'b0;
        settle();
        check("nto_done_stall", 32'(cpu_stall), 32'd0);
        check("nto_rdata", cpu_rdata, 32'h0BAD_CAFE);
        check("nto_err", 32'(cpu_bus_err), 32'd0);
`endif
        nxt();
        cpu_en = 1'b0;
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
